commit_stage: RTL and testbench

In-order retirement stage directly downstream of the ROB. Each cycle it examines the two oldest ROB entries and decides which of them retire. It returns the per-slot `commit_req` to the ROB, writes retired results into the architectural register file, and releases retired stores to the store buffer. On an exception or a branch mispredict it raises the pipeline-wide flush and redirect.

---
 rtl/commit_stage_pkg.sv | 26 ++
 rtl/commit_stage_slot_check.sv | 28 ++
 rtl/commit_stage.sv | 150 +++++++++++++++
 tb/tb_commit_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/commit_stage_pkg.sv
// Shared types for the in-order commit stage: the ROB commit bundle,
// the commit FSM state encoding and the default exception entry point.
package commit_stage_pkg;

  localparam int ROB_WIDTH = 5;

  localparam logic [31:0] EENTRY_DEFAULT = 32'h1c00_8000;

  typedef struct packed {
    logic        c_valid;
    logic [4:0]  w_areg;
    logic        w_reg;
    logic        w_mem;
    logic [31:0] w_data;
    logic [31:0] pc;
    logic        exception;
    logic        mispredict;
    logic [31:0] redirect_pc;
  } rob_commit_pkg_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_e;

endpackage

// File: rtl/commit_stage_slot_check.sv
// commit_slot_check: per-slot retire eligibility and ARF-write qualification.
// Ports: en (older slots allow this one), info (ROB entry), sb_ready,
//        ok (slot retires), arf_we (slot writes ARF), st_req (store wants SB).
module commit_slot_check
  import commit_stage_pkg::*;
(
  input  logic            en,
  input  rob_commit_pkg_t info,
  input  logic            sb_ready,
  output logic            ok,
  output logic            arf_we,
  output logic            st_req
);

  logic need_sb;

  // A faulting store never reaches the store buffer, so it does not
  // wait on it either; otherwise it could stall forever.
  assign need_sb = info.w_mem && !info.exception;

  assign st_req = en && info.c_valid && need_sb;

  assign ok = en && info.c_valid && (!need_sb || sb_ready);

  assign arf_we = ok && info.w_reg && !info.exception
                  && (info.w_areg != 5'd0);

endmodule

// File: rtl/commit_stage.sv
// commit_stage: retires up to two oldest ROB entries per cycle, writes the
// ARF, releases stores, and raises flush/redirect on exception/mispredict.
// Ports: clk, rst (async high), commit_info_i[2], commit_req_o[2],
//        arf_we_o/arf_waddr_o/arf_wdata_o, sb_commit_valid_o/_ready_i,
//        flush_o, redirect_valid_o, redirect_pc_o,
//        perf_commit_cnt_o (only with COMMIT_PERF_CNT_EN defined).
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter logic [31:0] EENTRY    = EENTRY_DEFAULT,
  parameter int          ROB_DEPTH = 1 << ROB_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  rob_commit_pkg_t [1:0] commit_info_i,
  output logic [1:0]            commit_req_o,
  output logic [1:0]            arf_we_o,
  output logic [1:0][4:0]       arf_waddr_o,
  output logic [1:0][31:0]      arf_wdata_o,
  output logic                  sb_commit_valid_o,
  input  logic                  sb_commit_ready_i,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_pc_o
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]           perf_commit_cnt_o
`endif
);

  commit_state_e state_q;

  logic [1:0] en;
  logic [1:0] ok;
  logic [1:0] we;
  logic [1:0] st;

  logic        ev0;
  logic        ev1;
  logic        ev;
  logic [31:0] tgt;

  logic        flush_q;
  logic [31:0] rpc_q;

  rob_commit_pkg_t s0;
  rob_commit_pkg_t s1;

  assign s0 = commit_info_i[0];
  assign s1 = commit_info_i[1];

  // Slot 1 only follows a clean slot 0, and never as a second store.
  always_comb begin
    en[0] = (state_q == RUN);
    en[1] = ok[0] && !s0.exception && !s0.mispredict
            && !(s0.w_mem && s1.w_mem);
  end

  commit_slot_check u_chk0 (
    .en       (en[0]),
    .info     (s0),
    .sb_ready (sb_commit_ready_i),
    .ok       (ok[0]),
    .arf_we   (we[0]),
    .st_req   (st[0])
  );

  commit_slot_check u_chk1 (
    .en       (en[1]),
    .info     (s1),
    .sb_ready (sb_commit_ready_i),
    .ok       (ok[1]),
    .arf_we   (we[1]),
    .st_req   (st[1])
  );

  assign commit_req_o      = ok;
  assign sb_commit_valid_o = st[0] || st[1];

  // Slot 0 events block slot 1, so at most one slot can fire here;
  // exception wins over mispredict inside a slot.
  always_comb begin
    ev0 = ok[0] && (s0.exception || s0.mispredict);
    ev1 = ok[1] && (s1.exception || s1.mispredict);
    ev  = ev0 || ev1;
    tgt = 32'd0;
    if (ev0) begin
      tgt = s0.exception ? EENTRY : s0.redirect_pc;
    end else if (ev1) begin
      tgt = s1.exception ? EENTRY : s1.redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      flush_q <= 1'b0;
      rpc_q   <= 32'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ev) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
      flush_q <= ev;
      rpc_q   <= ev ? tgt : 32'd0;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = flush_q;
  assign redirect_pc_o    = rpc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arf_we_o    <= 2'b00;
      arf_waddr_o <= '0;
      arf_wdata_o <= '0;
    end else begin
      arf_we_o       <= we;
      arf_waddr_o[0] <= s0.w_areg;
      arf_waddr_o[1] <= s1.w_areg;
      arf_wdata_o[0] <= s0.w_data;
      arf_wdata_o[1] <= s1.w_data;
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 64'd0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 64'(ok[0]) + 64'(ok[1]);
    end
  end

  assign perf_commit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_commit_stage.sv
// Directed self-checking bench for commit_stage.
// Drives ROB entries and checks retire, ARF, store and flush behaviour.
module tb_commit_stage;
  import commit_stage_pkg::*;

  logic                  clk;
  logic                  rst;
  rob_commit_pkg_t [1:0] ci;
  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0][4:0]       waddr;
  logic [1:0][31:0]      wdata;
  logic                  sb_valid;
  logic                  sb_ready;
  logic                  flush;
  logic                  rvalid;
  logic [31:0]           rpc;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0]           perf;
`endif

  int total;
  int bad;

  commit_stage dut (
    .clk               (clk),
    .rst               (rst),
    .commit_info_i     (ci),
    .commit_req_o      (req),
    .arf_we_o          (we),
    .arf_waddr_o       (waddr),
    .arf_wdata_o       (wdata),
    .sb_commit_valid_o (sb_valid),
    .sb_commit_ready_i (sb_ready),
    .flush_o           (flush),
    .redirect_valid_o  (rvalid),
    .redirect_pc_o     (rpc)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .perf_commit_cnt_o (perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rob_commit_pkg_t mk(
    input logic v, input logic [4:0] a, input logic r, input logic m,
    input logic [31:0] d, input logic e, input logic p,
    input logic [31:0] t);
    rob_commit_pkg_t x;
    x = '0;
    x.c_valid = v;
    x.w_areg = a;
    x.w_reg = r;
    x.w_mem = m;
    x.w_data = d;
    x.pc = 32'h1c00_0000;
    x.exception = e;
    x.mispredict = p;
    x.redirect_pc = t;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    sb_ready = 1'b0;
    ci = '0;
    #2;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rpc", 64'(rpc), 64'd0);
    chk("rst_sbv", 64'(sb_valid), 64'd0);
    step();
    rst = 1'b0;
    step();

    // empty ROB
    chk("empty_req", 64'(req), 64'd0);

    // dual ALU retire
    ci[0] = mk(1, 5'd3, 1, 0, 32'h11, 0, 0, 0);
    ci[1] = mk(1, 5'd5, 1, 0, 32'h22, 0, 0, 0);
    #1;
    chk("dual_req", 64'(req), 64'b11);
    chk("dual_sbv", 64'(sb_valid), 64'd0);
    step();
    ci = '0;
    chk("dual_we", 64'(we), 64'b11);
    chk("dual_wa0", 64'(waddr[0]), 64'd3);
    chk("dual_wa1", 64'(waddr[1]), 64'd5);
    chk("dual_wd0", 64'(wdata[0]), 64'h11);
    chk("dual_wd1", 64'(wdata[1]), 64'h22);
    chk("dual_flush", 64'(flush), 64'd0);

    // store backpressure
    ci[0] = mk(1, 5'd0, 0, 1, 32'h0, 0, 0, 0);
    ci[1] = mk(1, 5'd7, 1, 0, 32'h77, 0, 0, 0);
    sb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req", 64'(req), 64'd0);
      chk("bp_sbv", 64'(sb_valid), 64'd1);
      step();
      chk("bp_we", 64'(we), 64'd0);
    end
    sb_ready = 1'b1;
    #1;
    chk("bp_go_req", 64'(req), 64'b11);
    chk("bp_go_sbv", 64'(sb_valid), 64'd1);
    step();
    ci = '0;
    sb_ready = 1'b0;
    chk("bp_go_we", 64'(we), 64'b10);
    chk("bp_go_wa1", 64'(waddr[1]), 64'd7);

    // slot 0 exception
    ci[0] = mk(1, 5'd4, 1, 0, 32'h44, 1, 0, 0);
    ci[0].pc = 32'h1c00_0100;
    ci[1] = mk(1, 5'd6, 1, 0, 32'h66, 0, 0, 0);
    #1;
    chk("exc_req", 64'(req), 64'b01);
    step();
    chk("exc_we", 64'(we), 64'd0);
    chk("exc_flush", 64'(flush), 64'd1);
    chk("exc_rvalid", 64'(rvalid), 64'd1);
    chk("exc_rpc", 64'(rpc), 64'h1c00_8000);
    chk("exc_fl_req", 64'(req), 64'd0);
    chk("exc_fl_sbv", 64'(sb_valid), 64'd0);
    ci = '0;
    step();
    chk("exc_flush_off", 64'(flush), 64'd0);
    chk("exc_rvalid_off", 64'(rvalid), 64'd0);
    chk("exc_rpc_off", 64'(rpc), 64'd0);

    // slot 1 mispredict
    ci[0] = mk(1, 5'd1, 1, 0, 32'haa, 0, 0, 0);
    ci[1] = mk(1, 5'd2, 1, 0, 32'hbb, 0, 1, 32'h1c00_0400);
    #1;
    chk("mis_req", 64'(req), 64'b11);
    step();
    ci = '0;
    chk("mis_we", 64'(we), 64'b11);
    chk("mis_wd1", 64'(wdata[1]), 64'hbb);
    chk("mis_flush", 64'(flush), 64'd1);
    chk("mis_rpc", 64'(rpc), 64'h1c00_0400);
    step();
    chk("mis_flush_off", 64'(flush), 64'd0);

    // two stores together
    sb_ready = 1'b1;
    ci[0] = mk(1, 5'd0, 0, 1, 32'h0, 0, 0, 0);
    ci[1] = mk(1, 5'd0, 0, 1, 32'h0, 0, 0, 0);
    #1;
    chk("st2_req", 64'(req), 64'b01);
    chk("st2_sbv", 64'(sb_valid), 64'd1);
    step();
    ci[1] = '0;
    #1;
    chk("st2_next_req", 64'(req), 64'b01);
    step();
    ci = '0;
    sb_ready = 1'b0;

    // r0 is never written
    ci[0] = mk(1, 5'd0, 1, 0, 32'h55, 0, 0, 0);
    #1;
    chk("r0_req", 64'(req), 64'b01);
    step();
    ci = '0;
    chk("r0_we", 64'(we), 64'd0);

    // reset in FLUSH
    ci[0] = mk(1, 5'd9, 1, 0, 32'h99, 0, 1, 32'h1c00_0800);
    #1;
    chk("rf_req", 64'(req), 64'b01);
    step();
    ci = '0;
    chk("rf_flush", 64'(flush), 64'd1);
    chk("rf_we", 64'(we), 64'b01);
    #1;
    rst = 1'b1;
    #1;
    chk("rf_flush_rst", 64'(flush), 64'd0);
    chk("rf_rvalid_rst", 64'(rvalid), 64'd0);
    chk("rf_rpc_rst", 64'(rpc), 64'd0);
    chk("rf_we_rst", 64'(we), 64'd0);
    step();
    rst = 1'b0;
    ci[0] = mk(1, 5'd8, 1, 0, 32'h88, 0, 0, 0);
    #1;
    chk("rf_run_req", 64'(req), 64'b01);
    step();
    ci = '0;
    chk("rf_run_we", 64'(we), 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
